spi_dac_sequencer: RTL and testbench

- Parametrised successor to the single-channel sound DAC shifter; drives a multi-channel SPI DAC such as the LTC2624 class.
- Latches one sample per channel and emits one 32-bit write-and-update frame per enabled channel, in ascending channel order.
- Generates its own divided SCLK, an active-low chip select, and a ready/valid upstream handshake.
- Sits between the sound mixer and the DAC pins.

---
 rtl/spi_dac_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_spi_dac_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_dac_sequencer
//  Description : Multi-channel SPI DAC frame sequencer. Latches one sample
//                per channel on a ready/valid accept, then emits one 32-bit
//                write-and-update frame per enabled channel in ascending
//                channel order, with divided SCLK and active-low chip select.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_dac_sequencer #(
    parameter int         DATA_W  = 12,
    parameter int         NUM_CH  = 4,
    parameter int         CLK_DIV = 2,
    parameter logic [3:0] COMMAND = 4'b0011,
    parameter int         GAP_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic [NUM_CH*DATA_W-1:0] samples,
    input  logic [NUM_CH-1:0]        ch_mask,
    output logic                     sclk,
    output logic                     mosi,
    output logic                     cs_n,
    output logic                     busy,
    output logic                     frame_done
);

    // Counter widths sized so the terminal count is always representable.
    localparam int c_div_w = $clog2(CLK_DIV + 1);
    localparam int c_gap_w = $clog2(GAP_CYC + 1);

    localparam logic [c_div_w-1:0] c_div_last   = c_div_w'(CLK_DIV - 1);
    localparam logic [c_gap_w-1:0] c_gap_last   = c_gap_w'(GAP_CYC - 1);
    // Only consulted when GAP_CYC >= 2; the frame_done pulse is scheduled
    // one cycle early so that the registered output lands on the last cycle.
    localparam logic [c_gap_w-1:0] c_gap_pre    = c_gap_w'(GAP_CYC - 2);
    localparam logic               c_gap_single = 1'(GAP_CYC == 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_GAP   = 3'd3,
        S_DONE0 = 3'd4
    } state_t;

    state_t                     r_state;
    logic [NUM_CH*DATA_W-1:0]   r_samples;
    logic [NUM_CH-1:0]          r_pending;
    logic [30:0]                r_shreg;
    logic [c_div_w-1:0]         r_div_cnt;
    logic [4:0]                 r_bit_cnt;
    logic [c_gap_w-1:0]         r_gap_cnt;

    logic [NUM_CH-1:0]          w_src_mask;
    logic [NUM_CH*DATA_W-1:0]   w_src_samples;
    logic                       w_found;
    logic [3:0]                 w_idx;
    logic [DATA_W-1:0]          w_sample;
    logic [15:0]                w_just;
    logic [31:0]                w_word;
    logic [NUM_CH-1:0]          w_rest;

    // In IDLE the next frame comes from the live inputs (accept edge);
    // otherwise from the latched set and the channels still pending.
    assign w_src_mask    = (r_state == S_IDLE) ? ch_mask : r_pending;
    assign w_src_samples = (r_state == S_IDLE) ? samples : r_samples;

    // Lowest-indexed enabled channel; search is bounded to 0..NUM_CH-1.
    always_comb begin
        w_found = 1'b0;
        w_idx   = 4'd0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_src_mask[c]) begin
                w_found = 1'b1;
                w_idx   = 4'(c);
            end
        end
    end

    assign w_sample = DATA_W'(w_src_samples >> (int'(w_idx) * DATA_W));
    // Left-justify the sample in 16 bits with zero fill.
    assign w_just   = 16'(w_sample) << (16 - DATA_W);
    assign w_word   = {8'hFF, COMMAND, w_idx, w_just};
    assign w_rest   = w_src_mask & ~(NUM_CH'(1) << w_idx);

    // Sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_samples    <= '0;
            r_pending    <= '0;
            r_shreg      <= '0;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            sample_ready <= 1'b1;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
            cs_n         <= 1'b1;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sample_valid && sample_ready) begin
                        r_samples    <= samples;
                        r_pending    <= w_rest;
                        sample_ready <= 1'b0;
                        busy         <= 1'b1;
                        if (w_found) begin
                            r_state   <= S_SETUP;
                            r_div_cnt <= '0;
                            r_shreg   <= w_word[30:0];
                            mosi      <= w_word[31];
                            sclk      <= 1'b0;
                            cs_n      <= 1'b0;
                        end else begin
                            r_state <= S_DONE0;
                        end
                    end
                end

                S_SETUP: begin
                    if (r_div_cnt == c_div_last) begin
                        r_state   <= S_SHIFT;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (r_div_cnt == c_div_last) begin
                        r_div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            // Falling transition: the only place mosi moves.
                            sclk <= 1'b0;
                            if (r_bit_cnt == 5'd31) begin
                                r_state    <= S_GAP;
                                r_gap_cnt  <= '0;
                                cs_n       <= 1'b1;
                                mosi       <= 1'b0;
                                frame_done <= c_gap_single;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                                mosi      <= r_shreg[30];
                                r_shreg   <= {r_shreg[29:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    if (r_gap_cnt == c_gap_last) begin
                        if (w_found) begin
                            r_state   <= S_SETUP;
                            r_pending <= w_rest;
                            r_div_cnt <= '0;
                            r_shreg   <= w_word[30:0];
                            mosi      <= w_word[31];
                            sclk      <= 1'b0;
                            cs_n      <= 1'b0;
                        end else begin
                            r_state      <= S_IDLE;
                            busy         <= 1'b0;
                            sample_ready <= 1'b1;
                        end
                    end else begin
                        r_gap_cnt  <= r_gap_cnt + 1'b1;
                        frame_done <= (r_gap_cnt == c_gap_pre);
                    end
                end

                S_DONE0: begin
                    r_state      <= S_IDLE;
                    busy         <= 1'b0;
                    sample_ready <= 1'b1;
                end

                default: begin
                    r_state      <= S_IDLE;
                    busy         <= 1'b0;
                    sample_ready <= 1'b1;
                    cs_n         <= 1'b1;
                    sclk         <= 1'b0;
                    mosi         <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_dac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_dac_sequencer
//  Description : Self-checking bench for spi_dac_sequencer. Two instances:
//                defaults (12-bit, CLK_DIV=2) and an 8-bit, CLK_DIV=1 variant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_dac_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        va, vb;
    logic [47:0] sa;
    logic [31:0] sb;
    logic [3:0]  ma, mb;
    logic [1:0]  rdy, sclk, mosi, csn, busy, fd;

    spi_dac_sequencer dut_a (
        .clk(clk), .rst(rst), .sample_valid(va), .sample_ready(rdy[0]),
        .samples(sa), .ch_mask(ma), .sclk(sclk[0]), .mosi(mosi[0]),
        .cs_n(csn[0]), .busy(busy[0]), .frame_done(fd[0])
    );

    spi_dac_sequencer #(.DATA_W(8), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .sample_valid(vb), .sample_ready(rdy[1]),
        .samples(sb), .ch_mask(mb), .sclk(sclk[1]), .mosi(mosi[1]),
        .cs_n(csn[1]), .busy(busy[1]), .frame_done(fd[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Frame monitor: reconstructs each frame from the pins of both instances.
    logic        mon_clr = 1'b1;
    logic [31:0] fw    [2][8];
    int          fcyc  [2][8];
    int          frise [2][8];
    int          gaps  [2][8];
    int          nfr[2], ngap[2], fdc[2], bcyc[2], stray[2], ccyc[2], crise[2], grun[2];
    logic [31:0] cword[2];
    logic        psclk[2], pcs[2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mon_clr) begin
                nfr[d] <= 0; ngap[d] <= 0; fdc[d] <= 0; bcyc[d] <= 0;
                stray[d] <= 0; ccyc[d] <= 0; crise[d] <= 0; grun[d] <= 0;
                cword[d] <= '0; psclk[d] <= 1'b0; pcs[d] <= 1'b1;
            end else begin
                if (busy[d]) bcyc[d] <= bcyc[d] + 1;
                if (fd[d]) fdc[d] <= fdc[d] + 1;
                if (csn[d] && sclk[d]) stray[d] <= stray[d] + 1;
                if (!csn[d]) begin
                    if (pcs[d]) begin
                        if (nfr[d] > 0 && ngap[d] < 8) begin
                            gaps[d][ngap[d]] <= grun[d];
                            ngap[d] <= ngap[d] + 1;
                        end
                        ccyc[d] <= 1; crise[d] <= 0; cword[d] <= '0;
                    end else begin
                        ccyc[d] <= ccyc[d] + 1;
                        if (sclk[d] && !psclk[d]) begin
                            cword[d] <= {cword[d][30:0], mosi[d]};
                            crise[d] <= crise[d] + 1;
                        end
                    end
                end else begin
                    if (!pcs[d]) begin
                        if (nfr[d] < 8) begin
                            fw[d][nfr[d]]    <= cword[d];
                            fcyc[d][nfr[d]]  <= ccyc[d];
                            frise[d][nfr[d]] <= crise[d];
                        end
                        nfr[d]  <= nfr[d] + 1;
                        grun[d] <= busy[d] ? 1 : 0;
                    end else if (busy[d]) begin
                        grun[d] <= grun[d] + 1;
                    end
                end
                psclk[d] <= sclk[d];
                pcs[d]   <= csn[d];
            end
        end
    end

    typedef struct {
        int               d;
        logic [3:0]       mask;
        logic [47:0]      samp;
        int               nf;
        logic [3:0][31:0] w;     // w[0] is the first frame
        int               cyc;   // cs_n-low clk cycles per frame
    } vec_t;

    vec_t vecs[8];

    task automatic clear_mon();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (busy[d] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy[d]), 32'd0);
        @(negedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int exp_b;
        clear_mon();
        @(negedge clk);
        chk($sformatf("v%0d_ready_before", k), 32'(rdy[v.d]), 32'd1);
        if (v.d == 0) begin sa = v.samp; ma = v.mask; va = 1'b1; end
        else          begin sb = v.samp[31:0]; mb = v.mask; vb = 1'b1; end
        @(negedge clk);
        va = 1'b0; vb = 1'b0;
        sa = ~sa; sb = ~sb; ma = ~ma; mb = ~mb;   // must be ignored while busy
        chk($sformatf("v%0d_busy_accept", k), 32'(busy[v.d]), 32'd1);
        chk($sformatf("v%0d_ready_accept", k), 32'(rdy[v.d]), 32'd0);
        chk($sformatf("v%0d_csn_accept", k), 32'(csn[v.d]), (v.nf == 0) ? 32'd1 : 32'd0);
        wait_idle(v.d);
        exp_b = (v.nf == 0) ? 1 : v.nf * (v.cyc + 2);
        chk($sformatf("v%0d_frames", k), 32'(nfr[v.d]), 32'(v.nf));
        chk($sformatf("v%0d_frame_done", k), 32'(fdc[v.d]), 32'(v.nf));
        chk($sformatf("v%0d_busy_cycles", k), 32'(bcyc[v.d]), 32'(exp_b));
        chk($sformatf("v%0d_stray_sclk", k), 32'(stray[v.d]), 32'd0);
        chk($sformatf("v%0d_ready_after", k), 32'(rdy[v.d]), 32'd1);
        for (int i = 0; i < v.nf && i < 4; i++) begin
            chk($sformatf("v%0d_word%0d", k, i), fw[v.d][i], v.w[i]);
            chk($sformatf("v%0d_cyc%0d", k, i), 32'(fcyc[v.d][i]), 32'(v.cyc));
            chk($sformatf("v%0d_rise%0d", k, i), 32'(frise[v.d][i]), 32'd32);
        end
        chk($sformatf("v%0d_ngap", k), 32'(ngap[v.d]), (v.nf > 1) ? 32'(v.nf - 1) : 32'd0);
        for (int i = 0; i < ngap[v.d] && i < 8; i++)
            chk($sformatf("v%0d_gap%0d", k, i), 32'(gaps[v.d][i]), 32'd2);
    endtask

    initial begin
        va = 1'b0; vb = 1'b0; sa = '0; sb = '0; ma = '0; mb = '0;

        vecs[0] = '{0, 4'b0001, 48'h000000000ABC, 1, {32'h0, 32'h0, 32'h0, 32'hFF30ABC0}, 130};
        vecs[1] = '{0, 4'b1010, 48'hFFF000123000, 2, {32'h0, 32'h0, 32'hFF33FFF0, 32'hFF311230}, 130};
        vecs[2] = '{0, 4'b1111, 48'hAAA555FFF000, 4, {32'hFF33AAA0, 32'hFF325550, 32'hFF31FFF0, 32'hFF300000}, 130};
        vecs[3] = '{0, 4'b0000, 48'h123456789ABC, 0, {32'h0, 32'h0, 32'h0, 32'h0}, 130};
        vecs[4] = '{0, 4'b0100, 48'hFFF001FFFFFF, 1, {32'h0, 32'h0, 32'h0, 32'hFF320010}, 130};
        vecs[5] = '{1, 4'b0001, 48'h00000000005A, 1, {32'h0, 32'h0, 32'h0, 32'hFF305A00}, 65};
        vecs[6] = '{1, 4'b1100, 48'h000001FF0000, 2, {32'h0, 32'h0, 32'hFF330100, 32'hFF32FF00}, 65};
        vecs[7] = '{0, 4'b0001, 48'h0000000000C3, 1, {32'h0, 32'h0, 32'h0, 32'hFF300C30}, 130};

        // Reset, then idle for 20 cycles.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; mon_clr = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_ready", d), 32'(rdy[d]), 32'd1);
            chk($sformatf("rst%0d_csn", d), 32'(csn[d]), 32'd1);
            chk($sformatf("rst%0d_sclk", d), 32'(sclk[d]), 32'd0);
            chk($sformatf("rst%0d_mosi", d), 32'(mosi[d]), 32'd0);
            chk($sformatf("rst%0d_busy", d), 32'(busy[d]), 32'd0);
            chk($sformatf("rst%0d_fd_count", d), 32'(fdc[d]), 32'd0);
        end

        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        // sample_valid held high across the return to IDLE.
        clear_mon();
        @(negedge clk);
        sa = 48'h000000000111; ma = 4'b0001; va = 1'b1;
        begin
            int n = 0;
            while (!busy[0] && n < 10) begin @(negedge clk); n++; end
            chk("hold_busy_seen", 32'(busy[0]), 32'd1);
            n = 0;
            while (!rdy[0] && n < 500) begin @(negedge clk); n++; end
            chk("hold_ready_seen", 32'(rdy[0]), 32'd1);
        end
        @(negedge clk);
        chk("hold_reaccept_busy", 32'(busy[0]), 32'd1);
        chk("hold_reaccept_ready", 32'(rdy[0]), 32'd0);
        va = 1'b0;
        wait_idle(0);
        chk("hold_frames", 32'(nfr[0]), 32'd2);
        chk("hold_word1", fw[0][1], 32'hFF301110);
        chk("hold_fd", 32'(fdc[0]), 32'd2);

        // Reset asserted during bit 10 of a frame.
        clear_mon();
        @(negedge clk);
        sa = 48'h0000000005A5; ma = 4'b0001; va = 1'b1;
        @(negedge clk);
        va = 1'b0;
        begin
            int n = 0;
            while (crise[0] < 10 && n < 300) begin @(negedge clk); #1; n++; end
            chk("midrst_reached_bit10", 32'(crise[0]), 32'd10);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_csn", 32'(csn[0]), 32'd1);
        chk("midrst_sclk", 32'(sclk[0]), 32'd0);
        chk("midrst_ready", 32'(rdy[0]), 32'd1);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_mosi", 32'(mosi[0]), 32'd0);
        chk("midrst_fd", 32'(fd[0]), 32'd0);
        #1 rst = 1'b0;
        run_vec(vecs[7], 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
